// File: rtl/imu_burst_sequencer.sv
// imu_burst_sequencer
// Drives an I2C byte-level master to read a burst of IMU registers. After
// reset the sensor is configured once (INIT_REG <= INIT_VAL). Each frame then
// writes REG_START, reads BURST_LEN bytes and presents each one on data/address
// with a one-clk load strobe. NACKs and early STOPs are retried up to
// MAX_RETRY times before the block parks in ERROR.
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   internal_clk          : tick enable; the sequencer only advances on ticks
//   start, clear_err      : frame request / leave ERROR (sampled on ticks)
//   queued, nack, stop    : I2C master handshake status
//   data_valid, data_in   : read byte from the master
//   data_out              : byte to transmit
//   write_enable          : write request to the master
//   read_enable           : read request (low while the last byte is read)
//   address, data, load   : captured sample index/byte and its strobe
//   completed             : one-clk strobe when a frame finishes cleanly
//   busy, error           : status
//   retry_cnt             : retries used in the current frame
//   frame_count           : good frames since reset (wraps)
module imu_burst_sequencer #(
    parameter logic [7:0] INIT_REG    = 8'h6B,
    parameter logic [7:0] INIT_VAL    = 8'h00,
    parameter logic [7:0] REG_START   = 8'h3B,
    parameter int         BURST_LEN   = 14,
    parameter int         MAX_RETRY   = 3,
    parameter int         AUTO_PERIOD = 0,
    localparam int        IDX_W       = $clog2(BURST_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             internal_clk,
    input  logic             start,
    input  logic             clear_err,
    input  logic             queued,
    input  logic             nack,
    input  logic             stop,
    input  logic             data_valid,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    output logic             write_enable,
    output logic             read_enable,
    output logic [IDX_W-1:0] address,
    output logic [7:0]       data,
    output logic             load,
    output logic             completed,
    output logic             busy,
    output logic             error,
    output logic [1:0]       retry_cnt,
    output logic [15:0]      frame_count
);

    localparam int AUTO_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_REG,
        S_INIT_VAL,
        S_READ_ADDR,
        S_READ_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_reg;
    logic              init_done_reg;
    logic [AUTO_W-1:0] auto_cnt_reg;
    logic [IDX_W-1:0]  index_reg;
    logic [7:0]        data_out_reg;
    logic              write_enable_reg;
    logic              read_enable_reg;
    logic [IDX_W-1:0]  address_reg;
    logic [7:0]        data_reg;
    logic              load_reg;
    logic              completed_reg;
    logic [1:0]        retry_cnt_reg;
    logic [15:0]       frame_count_reg;

    logic              auto_fire;
    logic              trigger;
    logic              active;
    logic              burst_full;
    logic              fail_event;
    logic              retry_ok;
    logic [IDX_W-1:0]  index_inc;
    state_t            restart_state;

    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            assign auto_fire = (auto_cnt_reg == AUTO_W'(AUTO_PERIOD - 1));
        end else begin : g_no_auto
            assign auto_fire = 1'b0;
        end
    endgenerate

    assign trigger       = start | auto_fire;
    assign active        = (state_reg == S_INIT_REG) || (state_reg == S_INIT_VAL) ||
                           (state_reg == S_READ_ADDR) || (state_reg == S_READ_DATA);
    assign burst_full    = (index_reg == IDX_W'(BURST_LEN));
    // nack wins over everything; a STOP before the burst is full is a failed
    // transfer, but only when no byte arrives on the same tick (data has priority).
    assign fail_event    = active && (nack || ((state_reg == S_READ_DATA) && !data_valid &&
                                               stop && !burst_full));
    assign retry_ok      = (32'(retry_cnt_reg) < MAX_RETRY);
    assign restart_state = init_done_reg ? S_READ_ADDR : S_INIT_REG;
    assign index_inc     = index_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            init_done_reg    <= 1'b0;
            auto_cnt_reg     <= '0;
            index_reg        <= '0;
            data_out_reg     <= 8'h00;
            write_enable_reg <= 1'b0;
            read_enable_reg  <= 1'b0;
            address_reg      <= '0;
            data_reg         <= 8'hFF;
            load_reg         <= 1'b0;
            completed_reg    <= 1'b0;
            retry_cnt_reg    <= 2'd0;
            frame_count_reg  <= 16'd0;
        end else begin
            // Strobes last exactly one clk, independent of the tick enable.
            load_reg      <= 1'b0;
            completed_reg <= 1'b0;
            if (internal_clk) begin
                auto_cnt_reg <= '0;
                if (fail_event) begin
                    write_enable_reg <= 1'b0;
                    read_enable_reg  <= 1'b0;
                    if (retry_ok) begin
                        retry_cnt_reg <= retry_cnt_reg + 1'b1;
                        state_reg     <= restart_state;
                    end else begin
                        state_reg <= S_ERROR;
                    end
                end else begin
                    case (state_reg)
                        S_IDLE: begin
                            if (trigger) begin
                                retry_cnt_reg    <= 2'd0;
                                write_enable_reg <= 1'b1;
                                if (init_done_reg) begin
                                    data_out_reg <= REG_START;
                                    state_reg    <= S_READ_ADDR;
                                end else begin
                                    data_out_reg <= INIT_REG;
                                    state_reg    <= S_INIT_REG;
                                end
                            end else begin
                                auto_cnt_reg <= auto_cnt_reg + 1'b1;
                            end
                        end
                        S_INIT_REG: begin
                            write_enable_reg <= 1'b1;
                            if (queued) begin
                                data_out_reg <= INIT_VAL;
                                state_reg    <= S_INIT_VAL;
                            end else begin
                                data_out_reg <= INIT_REG;
                            end
                        end
                        S_INIT_VAL: begin
                            if (queued) begin
                                write_enable_reg <= 1'b0;
                                init_done_reg    <= 1'b1;
                                state_reg        <= S_READ_ADDR;
                            end
                        end
                        S_READ_ADDR: begin
                            if (queued) begin
                                write_enable_reg <= 1'b0;
                                // A one-byte burst is its own last byte, so no ACK-read.
                                read_enable_reg  <= (BURST_LEN > 1);
                                index_reg        <= '0;
                                state_reg        <= S_READ_DATA;
                            end else begin
                                data_out_reg     <= REG_START;
                                write_enable_reg <= 1'b1;
                                read_enable_reg  <= 1'b0;
                            end
                        end
                        S_READ_DATA: begin
                            if (data_valid) begin
                                if (!burst_full) begin
                                    data_reg    <= data_in;
                                    address_reg <= index_reg;
                                    index_reg   <= index_inc;
                                    load_reg    <= 1'b1;
                                    // Drop the read request ahead of the final byte so the
                                    // master NACKs it.
                                    if ((index_inc == IDX_W'(BURST_LEN)) ||
                                        (index_inc == IDX_W'(BURST_LEN - 1))) begin
                                        read_enable_reg <= 1'b0;
                                    end
                                end
                            end else if (stop) begin
                                read_enable_reg <= 1'b0;
                                completed_reg   <= 1'b1;
                                frame_count_reg <= frame_count_reg + 16'd1;
                                state_reg       <= S_DONE;
                            end
                        end
                        S_DONE: begin
                            state_reg <= S_IDLE;
                        end
                        S_ERROR: begin
                            write_enable_reg <= 1'b0;
                            read_enable_reg  <= 1'b0;
                            if (clear_err) begin
                                init_done_reg <= 1'b0;
                                state_reg     <= S_IDLE;
                            end
                        end
                        default: begin
                            state_reg <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign data_out     = data_out_reg;
    assign write_enable = write_enable_reg;
    assign read_enable  = read_enable_reg;
    assign address      = address_reg;
    assign data         = data_reg;
    assign load         = load_reg;
    assign completed    = completed_reg;
    assign busy         = (state_reg != S_IDLE) && (state_reg != S_ERROR);
    assign error        = (state_reg == S_ERROR);
    assign retry_cnt    = retry_cnt_reg;
    assign frame_count  = frame_count_reg;

endmodule

// File: tb/tb_imu_burst_sequencer.sv
// Testbench for imu_burst_sequencer: a randomized I2C master drives the main
// instance through clean frames, single NACK retries, persistent NACKs,
// early STOPs and mid-frame resets; a second instance with AUTO_PERIOD=5
// exercises the auto-trigger timer. Expectations come from a frame-level model.
module tb_imu_burst_sequencer;

    localparam int         BURST_LEN = 14;
    localparam int         MAX_RETRY = 3;
    localparam int         AUTO_A    = 5;
    localparam logic [7:0] INIT_REG  = 8'h6B;
    localparam logic [7:0] INIT_VAL  = 8'h00;
    localparam logic [7:0] REG_START = 8'h3B;
    localparam int         IDX_W     = $clog2(BURST_LEN + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, internal_clk, start, clear_err, queued, nack, stop, data_valid;
    logic [7:0]       data_in;
    logic [7:0]       data_out;
    logic             write_enable, read_enable, load, completed, busy, error;
    logic [IDX_W-1:0] address;
    logic [7:0]       data;
    logic [1:0]       retry_cnt;
    logic [15:0]      frame_count;

    logic             nack_a, clear_err_a;
    logic [7:0]       data_out_a, data_a;
    logic             write_enable_a, read_enable_a, load_a, completed_a, busy_a, error_a;
    logic [IDX_W-1:0] address_a;
    logic [1:0]       retry_cnt_a;
    logic [15:0]      frame_count_a;

    imu_burst_sequencer dut (
        .clk(clk), .reset(reset), .internal_clk(internal_clk), .start(start),
        .clear_err(clear_err), .queued(queued), .nack(nack), .stop(stop),
        .data_valid(data_valid), .data_in(data_in), .data_out(data_out),
        .write_enable(write_enable), .read_enable(read_enable), .address(address),
        .data(data), .load(load), .completed(completed), .busy(busy), .error(error),
        .retry_cnt(retry_cnt), .frame_count(frame_count)
    );

    imu_burst_sequencer #(.AUTO_PERIOD(AUTO_A)) dut_auto (
        .clk(clk), .reset(reset), .internal_clk(internal_clk), .start(1'b0),
        .clear_err(clear_err_a), .queued(1'b0), .nack(nack_a), .stop(1'b0),
        .data_valid(1'b0), .data_in(8'h00), .data_out(data_out_a),
        .write_enable(write_enable_a), .read_enable(read_enable_a), .address(address_a),
        .data(data_a), .load(load_a), .completed(completed_a), .busy(busy_a),
        .error(error_a), .retry_cnt(retry_cnt_a), .frame_count(frame_count_a)
    );

    int          checks   = 0;
    int          failures = 0;
    int          comp_cnt = 0;
    logic        tick_q   = 1'b0;
    logic [15:0] exp_loads[$];
    logic [15:0] obs_loads[$];
    logic [7:0]  fbytes[BURST_LEN];
    logic        init_done_m;
    logic [15:0] frame_count_m;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (load) obs_loads.push_back({8'(address), data});
        if (completed) comp_cnt++;
    end

    // One clk with a random tick enable; tick_q records whether that edge ticked.
    task automatic cycle();
        internal_clk = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        tick_q = internal_clk;
        #1;
    endtask

    task automatic hold_tick();
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!tick_q && n < 50);
    endtask

    task automatic wait_we();
        int g = 0;
        while (write_enable !== 1'b1 && g < 100) begin
            cycle();
            g++;
        end
        check_val("we_seen", write_enable, 1);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy !== 1'b0 && g < 100) begin
            cycle();
            g++;
        end
        check_val("idle", busy, 0);
    endtask

    task automatic do_write(input logic [7:0] exp, input string tag);
        wait_we();
        repeat ($urandom_range(0, 2)) cycle();
        check_val(tag, data_out, exp);
        queued = 1'b1;
        hold_tick();
        queued = 1'b0;
    endtask

    task automatic do_nack(input logic [7:0] exp);
        wait_we();
        repeat ($urandom_range(0, 2)) cycle();
        check_val("nack_dout", data_out, exp);
        nack = 1'b1;
        hold_tick();
        nack = 1'b0;
    endtask

    task automatic do_read(input int n, input bit poke_start);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) cycle();
            check_val("re_level", read_enable, (i < BURST_LEN - 1));
            exp_loads.push_back({8'(i), fbytes[i]});
            data_in    = fbytes[i];
            data_valid = 1'b1;
            start      = poke_start && (i == 2);
            hold_tick();
            data_valid = 1'b0;
            start      = 1'b0;
        end
    endtask

    task automatic do_stop();
        repeat ($urandom_range(0, 2)) cycle();
        stop = 1'b1;
        hold_tick();
        stop = 1'b0;
    endtask

    task automatic check_loads(input string tag);
        check_val({tag, "_nload"}, obs_loads.size(), exp_loads.size());
        for (int i = 0; i < exp_loads.size() && i < obs_loads.size(); i++)
            check_val(tag, obs_loads[i], exp_loads[i]);
    endtask

    task automatic check_reset_state();
        check_val("rst_dout", data_out, 8'h00);
        check_val("rst_we", write_enable, 0);
        check_val("rst_re", read_enable, 0);
        check_val("rst_addr", address, 0);
        check_val("rst_data", data, 8'hFF);
        check_val("rst_load", load, 0);
        check_val("rst_comp", completed, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_err", error, 0);
        check_val("rst_retry", retry_cnt, 0);
        check_val("rst_fcnt", frame_count, 0);
    endtask

    // scen: 0 clean (with a start poke while busy), 1 single NACK on REG_START,
    // 2 persistent NACK -> ERROR, 3 early STOP then retry, 4 reset mid-burst
    task automatic run_frame(input int scen, input int fidx);
        int k;
        int comp0;
        int retries;
        for (int i = 0; i < BURST_LEN; i++)
            fbytes[i] = (fidx == 0) ? 8'(8'h10 + i) : 8'($urandom);
        exp_loads.delete();
        wait_idle();
        obs_loads.delete();
        comp0   = comp_cnt;
        retries = 0;
        start   = 1'b1;
        hold_tick();
        start   = 1'b0;
        check_val("retry_clr", retry_cnt, 0);
        if (scen == 2) begin
            for (int a = 0; a <= MAX_RETRY; a++)
                do_nack(init_done_m ? REG_START : INIT_REG);
            check_val("pers_err", error, 1);
            check_val("pers_busy", busy, 0);
            check_val("pers_retry", retry_cnt, MAX_RETRY);
            clear_err = 1'b1;
            hold_tick();
            clear_err = 1'b0;
            check_val("clr_err", error, 0);
            check_val("clr_busy", busy, 0);
            init_done_m = 1'b0;
            $display("frame %0d scen=%0d error path, frame_count=%0d", fidx, scen, frame_count);
            return;
        end
        if (!init_done_m) begin
            do_write(INIT_REG, "wr_init_reg");
            do_write(INIT_VAL, "wr_init_val");
            init_done_m = 1'b1;
        end
        if (scen == 1) begin
            do_nack(REG_START);
            retries = 1;
            check_val("retry_nack", retry_cnt, 1);
        end
        do_write(REG_START, "wr_start");
        if (scen == 3 || scen == 4) begin
            k = $urandom_range(1, BURST_LEN - 1);
            do_read(k, 1'b0);
            if (scen == 4) begin
                reset        = 1'b1;
                internal_clk = 1'b0;
                @(posedge clk);
                #1;
                check_reset_state();
                reset = 1'b0;
                repeat (3) cycle();
                check_val("rst_no_comp", comp_cnt - comp0, 0);
                check_loads("rst_loads");
                init_done_m   = 1'b0;
                frame_count_m = 16'd0;
                $display("frame %0d scen=%0d reset after %0d bytes", fidx, scen, k);
                return;
            end
            do_stop();
            retries = 1;
            check_val("early_retry", retry_cnt, 1);
            check_val("early_busy", busy, 1);
            do_write(REG_START, "wr_retry");
        end
        do_read(BURST_LEN, scen == 0);
        do_stop();
        frame_count_m = frame_count_m + 16'd1;
        cycle();
        wait_idle();
        repeat (8) cycle();
        check_val("start_ignored", busy, 0);
        check_val("completed", comp_cnt - comp0, 1);
        check_val("fcnt", frame_count, frame_count_m);
        check_val("retry_end", retry_cnt, retries);
        check_loads("loads");
        $display("frame %0d scen=%0d loads=%0d frame_count=%0d", fidx, scen, obs_loads.size(), frame_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        reset = 1'b1; internal_clk = 1'b0; start = 1'b0; clear_err = 1'b0;
        queued = 1'b0; nack = 1'b0; stop = 1'b0; data_valid = 1'b0; data_in = 8'h00;
        nack_a = 1'b0; clear_err_a = 1'b0;
        init_done_m = 1'b0; frame_count_m = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;

        // No tick, no action even with start held.
        start = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_val("gate_busy", busy, 0);
        start = 1'b0;

        // Auto instance: trigger on the AUTO_A-th idle tick.
        n = 0; g = 0;
        while (busy_a !== 1'b1 && g < 200) begin
            cycle();
            if (tick_q) n++;
            g++;
        end
        check_val("auto_period", n, AUTO_A);
        check_val("auto_dout", data_out_a, INIT_REG);
        check_val("auto_we", write_enable_a, 1);
        nack_a = 1'b1;
        n = 0; g = 0;
        while (error_a !== 1'b1 && g < 200) begin
            cycle();
            if (tick_q) n++;
            g++;
        end
        check_val("auto_nacks", n, MAX_RETRY + 1);
        check_val("auto_retry", retry_cnt_a, MAX_RETRY);
        check_val("auto_busy_err", busy_a, 0);
        check_val("auto_en", {write_enable_a, read_enable_a, load_a, completed_a}, 0);
        check_val("auto_hold", {frame_count_a, 8'(address_a), data_a}, {16'd0, 8'd0, 8'hFF});
        nack_a = 1'b0;
        clear_err_a = 1'b1;
        hold_tick();
        clear_err_a = 1'b0;
        check_val("auto_clr", {busy_a, error_a}, 0);
        n = 0; g = 0;
        while (busy_a !== 1'b1 && g < 200) begin
            cycle();
            if (tick_q) n++;
            g++;
        end
        check_val("auto_period2", n, AUTO_A);
        nack_a = 1'b1;

        run_frame(0, 0);
        run_frame(0, 1);
        run_frame(1, 2);
        for (int f = 3; f < 15; f++) run_frame(int'($urandom_range(0, 4)), f);
        run_frame(3, 15);
        run_frame(2, 16);
        run_frame(0, 17);
        run_frame(4, 18);
        run_frame(0, 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
